// File: rtl/heartbeat_sequencer.sv
// Heartbeat sequencer: PWM LED "breathing" controller.
// Ramps a duty level 0 -> max, holds, ramps back to 0, holds, and repeats
// while en is high. Define HEARTBEAT_GAMMA_EN to apply a square-law
// brightness curve (duty*duty >> PWM_W) to the PWM compare level; the raw
// level is always what appears on the duty port.
module heartbeat_sequencer #(
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned STEP_PERIODS = 16,
  parameter int unsigned HOLD_STEPS   = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  output logic             led,
  output logic [PWM_W-1:0] duty,
  output logic [2:0]       phase,
  output logic             period_tick
);

  localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [PWM_W-1:0] LVL_MAX   = '1;
  localparam logic [PWM_W-1:0] LVL_ONE   = PWM_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_eff;
  logic [SW-1:0]    step_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             step_evt;
  logic             hold_done;

  // Brightness curve applied to the PWM compare level
`ifdef HEARTBEAT_GAMMA_EN
  logic [2*PWM_W-1:0] duty_sq;
  always_comb begin
    duty_sq  = {{PWM_W{1'b0}}, duty} * {{PWM_W{1'b0}}, duty};
    duty_eff = duty_sq[2*PWM_W-1:PWM_W];
  end
`else
  always_comb begin
    duty_eff = duty;
  end
`endif

  // State register; reset wins over en
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; en low returns to IDLE from anywhere
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      state_next = RAMP_UP;
        RAMP_UP:   if (step_evt && (duty >= (LVL_MAX - LVL_ONE))) state_next = HOLD_HIGH;
        HOLD_HIGH: if (hold_done) state_next = RAMP_DOWN;
        RAMP_DOWN: if (step_evt && (duty <= LVL_ONE)) state_next = HOLD_LOW;
        HOLD_LOW:  if (hold_done) state_next = RAMP_UP;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Outputs and internal step/hold events decoded from current state
  always_comb begin
    phase       = state;
    period_tick = (state != IDLE) && (pwm_cnt == LVL_MAX);
    step_evt    = period_tick && (step_cnt == STEP_LAST);
    hold_done   = step_evt && (hold_cnt == HOLD_LAST);
  end

  // Datapath: PWM, step and hold counters plus duty level; all cleared in IDLE or when en drops
  always_ff @(posedge clk) begin
    if (!n_rst || !en || (state == IDLE)) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
      duty     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + LVL_ONE;
      if (period_tick) begin
        step_cnt <= step_evt ? '0 : step_cnt + SW'(1);
      end
      // Hold counter only advances in hold phases and self-clears on expiry,
      // so it is always 0 on entry to the next hold phase
      if (((state == HOLD_HIGH) || (state == HOLD_LOW)) && step_evt) begin
        hold_cnt <= hold_done ? '0 : hold_cnt + HW'(1);
      end
      if (step_evt && (state == RAMP_UP) && (duty != LVL_MAX)) begin
        duty <= duty + LVL_ONE;
      end else if (step_evt && (state == RAMP_DOWN) && (duty != '0)) begin
        duty <= duty - LVL_ONE;
      end
    end
  end

  // Registered PWM compare: one cycle of latency behind pwm_cnt/duty
  always_ff @(posedge clk) begin
    if (!n_rst) led <= 1'b0;
    else        led <= (pwm_cnt < duty_eff);
  end

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// Testbench for heartbeat_sequencer (PWM_W=4, STEP_PERIODS=2, HOLD_STEPS=1).
// Stimulus pushes expected outputs into a scoreboard queue after each clock
// edge; a monitor on the falling edge pops and compares.
module tb_heartbeat_sequencer;

  logic       clk;
  logic       n_rst;
  logic       en;
  logic       led;
  logic [3:0] duty;
  logic [2:0] phase;
  logic       period_tick;

  heartbeat_sequencer #(
    .PWM_W(4),
    .STEP_PERIODS(2),
    .HOLD_STEPS(1)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .en(en),
    .led(led),
    .duty(duty),
    .phase(phase),
    .period_tick(period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         full;
    logic [2:0] ph;
    logic [3:0] du;
    logic       ld;
    logic       tk;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: cycles since entering RAMP_UP
  int   mt       = 0;
  bit   mrun     = 0;
  logic prev_cmp = 1'b0;

  function automatic logic [3:0] eff(input logic [3:0] d);
`ifdef HEARTBEAT_GAMMA_EN
    logic [7:0] sq;
    sq = {4'd0, d} * {4'd0, d};
    return sq[7:4];
`else
    return d;
`endif
  endfunction

  // One breathing cycle is 1024 clocks: 15 ramp steps, 1 hold, 15 ramp steps, 1 hold
  function automatic void model(input int t, output logic [2:0] ph, output logic [3:0] du);
    int k;
    k = (t % 1024) / 32;
    if (k < 15)       begin ph = 3'd1; du = 4'(k);      end
    else if (k == 15) begin ph = 3'd2; du = 4'd15;      end
    else if (k < 31)  begin ph = 3'd3; du = 4'(31 - k); end
    else              begin ph = 3'd4; du = 4'd0;       end
  endfunction

  task automatic push_exp(input string name, input bit full, input logic [2:0] ph,
                          input logic [3:0] du, input logic ld, input logic tk);
    exp_t x;
    x.name = name; x.full = full; x.ph = ph; x.du = du; x.ld = ld; x.tk = tk;
    sb.push_back(x);
  endtask

  task automatic cycle(input logic r, input logic e_in);
    logic [2:0] ph;
    logic [3:0] du;
    logic       tk;
    logic       led_e;
    n_rst = r;
    en    = e_in;
    @(posedge clk);
    #1;
    if (!r) begin
      mrun  = 0;
      led_e = 1'b0;
    end else begin
      led_e = prev_cmp;
      if (!e_in)      mrun = 0;
      else if (!mrun) begin mrun = 1; mt = 0; end
      else            mt++;
    end
    if (mrun) begin
      model(mt, ph, du);
      tk       = ((mt % 16) == 15);
      prev_cmp = ((mt % 16) < int'(eff(du)));
    end else begin
      ph = 3'd0; du = 4'd0; tk = 1'b0;
      prev_cmp = 1'b0;
    end
    push_exp("model", 1, ph, du, led_e, tk);
  endtask

  // Monitor: compare every queued expectation against the DUT outputs
  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      bad = (phase !== e.ph) || (duty !== e.du);
      if (e.full) bad = bad || (led !== e.ld) || (period_tick !== e.tk);
      if (bad) begin
        failures++;
        $display("FAIL %s t=%0d: got phase=%0d duty=%0d led=%0b tick=%0b, expected phase=%0d duty=%0d led=%0b tick=%0b (full=%0b)",
                 e.name, mt, phase, duty, led, period_tick, e.ph, e.du, e.ld, e.tk, e.full);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    en    = 1'b1;

    repeat (3) begin
      cycle(1'b0, 1'b1);
      push_exp("reset", 1, 3'd0, 4'd0, 1'b0, 1'b0);
    end

    cycle(1'b1, 1'b1);
    push_exp("start", 1, 3'd1, 4'd0, 1'b0, 1'b0);

    while (mt < 1100) begin
      cycle(1'b1, 1'b1);
      case (mt)
        15:   push_exp("tick15",   1, 3'd1, 4'd0,  1'b0, 1'b1);
        32:   push_exp("step1",    0, 3'd1, 4'd1,  1'b0, 1'b0);
        480:  push_exp("top",      0, 3'd2, 4'd15, 1'b0, 1'b0);
        512:  push_exp("down",     0, 3'd3, 4'd15, 1'b0, 1'b0);
        992:  push_exp("hold_low", 0, 3'd4, 4'd0,  1'b0, 1'b0);
        1024: push_exp("wrap",     0, 3'd1, 4'd0,  1'b0, 1'b0);
        default: ;
      endcase
    end

    cycle(1'b1, 1'b0);
    push_exp("toggle_drop", 0, 3'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    push_exp("restart", 1, 3'd1, 4'd0, 1'b0, 1'b0);

    while (mt < 710) cycle(1'b1, 1'b1);
    push_exp("duty9", 0, 3'd3, 4'd9, 1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    push_exp("en_off", 0, 3'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    push_exp("led_off", 1, 3'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    push_exp("reraise", 1, 3'd1, 4'd0, 1'b0, 1'b0);

    while (mt < 100) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    push_exp("mid_rst", 1, 3'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    push_exp("post_rst", 1, 3'd1, 4'd0, 1'b0, 1'b0);
    repeat (40) cycle(1'b1, 1'b1);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/heartbeat_sequencer.md
HEARTBEAT_SEQUENCER -- requirements
Module: heartbeat_sequencer

Interface
REQ-001 The block SHALL have the parameter PWM_W, default 8, giving the PWM counter and duty width in bits.
REQ-002 The block SHALL have the parameter STEP_PERIODS, default 16, giving the number of PWM periods per duty step (minimum 1).
REQ-003 The block SHALL have the parameter HOLD_STEPS, default 4, giving the number of steps spent in each hold phase (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: run request for the breathing sequence.
REQ-007 The block SHALL have port led, output, 1 bit: PWM drive for the LED.
REQ-008 The block SHALL have port duty, output, PWM_W bits: the current raw brightness level.
REQ-009 The block SHALL have port phase, output, 3 bits: FSM state, encoded 0 IDLE, 1 RAMP_UP, 2 HOLD_HIGH, 3 RAMP_DOWN, 4 HOLD_LOW.
REQ-010 The block SHALL have port period_tick, output, 1 bit: a one-cycle pulse on the last cycle of each PWM period.

Function
REQ-011 The block SHALL contain a free-running PWM counter pwm_cnt of PWM_W bits that increments every cycle when phase is not IDLE and wraps from 2^PWM_W-1 to 0.
REQ-012 period_tick SHALL be 1 exactly when phase is not IDLE and pwm_cnt equals 2^PWM_W-1.
REQ-013 led SHALL be registered and equal (pwm_cnt < duty_eff) from the previous cycle, giving 1 cycle of latency.
- At duty_eff = 0, led stays 0.
- At the maximum duty_eff, led is low for 1 cycle per period.
REQ-014 A step counter SHALL count period_ticks; when it reaches STEP_PERIODS it clears and issues an internal one-cycle step event.
REQ-015 In IDLE, duty, pwm_cnt and the step and hold counters SHALL be held at 0.
- IDLE moves to RAMP_UP on the cycle after en is sampled 1.
REQ-016 In RAMP_UP, duty SHALL increment by 1 on each step event; on the step at which duty becomes 2^PWM_W-1, the FSM moves to HOLD_HIGH.
REQ-017 In HOLD_HIGH, the FSM SHALL move to RAMP_DOWN after HOLD_STEPS step events, with duty unchanged.
REQ-018 In RAMP_DOWN, duty SHALL decrement by 1 on each step event; on the step at which duty becomes 0, the FSM moves to HOLD_LOW.
REQ-019 In HOLD_LOW, the FSM SHALL move to RAMP_UP after HOLD_STEPS step events; it repeats indefinitely while en=1.
REQ-020 duty SHALL saturate at 0 and 2^PWM_W-1 and never wrap.
REQ-021 en sampled 0 in any state SHALL force IDLE on the next cycle, clearing duty and all counters; led returns to 0 one cycle later.
REQ-022 If en toggles 1->0->1 on consecutive cycles, the sequence SHALL restart from IDLE, not resume.
REQ-023 When a step event and a hold-count expiry coincide, exactly one transition SHALL occur, with no duplicated or skipped step.

Reset
REQ-024 While n_rst is sampled 0, the block SHALL force phase=IDLE and duty=0, clear pwm_cnt, step and hold counters, and drive led=0 and period_tick=0.
REQ-025 Reset SHALL take priority over en in the same cycle.
REQ-026 Reset mid-ramp SHALL abandon the sequence; after release, operation resumes from IDLE per REQ-015.

Configuration
REQ-027 With macro HEARTBEAT_GAMMA_EN defined, duty_eff SHALL equal (duty*duty) >> PWM_W, computed at 2*PWM_W bits before the shift.
REQ-028 Without HEARTBEAT_GAMMA_EN, duty_eff SHALL equal duty; no multiplier is instantiated.
- The duty output is the raw level in both builds.

Verification
Bench parameters: PWM_W=4, STEP_PERIODS=2, HOLD_STEPS=1; PWM period is 16 cycles and one step is 32 cycles.
REQ-029 Apply reset for 3 cycles with en=1, then release -> phase=0, duty=0, led=0 during reset; phase=1 on the cycle after the first post-reset sampling of en=1.
REQ-030 Hold en=1 from the first RAMP_UP cycle -> duty=1 after 32 cycles; duty=15 and phase=2 after 480 cycles; phase=3 after 512 cycles.
REQ-031 Sample led at duty=15 without gamma -> led is high for 15 of 16 cycles per period; at duty=0, led is high for 0 of 16.
REQ-032 Run with gamma enabled, duty=8 -> duty_eff=4, so led is high for 4 of 16 cycles; duty=15 -> duty_eff=14.
REQ-033 Drop en to 0 while phase=3 and duty=9 -> phase=0 and duty=0 next cycle, led=0 the cycle after; re-raising en restarts with duty=0.
REQ-034 Run a full cycle 0->15->0 -> phase sequence 1,2,3,4,1, with period_tick pulsing every 16 cycles and no duty wrap.
